// File: rtl/i2s_rx_pkg.sv
// Shared FSM encoding and default sizes for the I2S ADC receiver.
package i2s_rx_pkg;

  localparam logic [1:0] HUNT  = 2'd0;
  localparam logic [1:0] LEFT  = 2'd1;
  localparam logic [1:0] RIGHT = 2'd2;

  localparam int DATA_WIDTH_DEF = 24;
  localparam int SLOT_BITS_DEF  = 32;
  localparam int SCLK_DIV_DEF   = 12;
  localparam int BIT_CNT_W_DEF  = $clog2(SLOT_BITS_DEF + 1);

  // Bit counter must be able to hold SLOT_BITS itself, since it saturates there.
  function automatic int bit_cnt_w(input int slot_bits);
    return $clog2(slot_bits + 1);
  endfunction

endpackage

// File: rtl/i2s_edge_sync.sv
// Two-flop synchroniser for one asynchronous I2S pin plus a history flop for rising-edge detection.
module i2s_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_hist <= 1'b0;
    end else begin
      r_s1   <= i_pin;
      r_s2   <= r_s1;
      r_hist <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_hist;

endmodule

// File: rtl/i2s_adc_receiver.sv
// I2S stereo ADC receiver: deserialises left/right words into I/Q pairs on a stb/ack port and
// generates the ADC master clock. Optional dropped-pair counter under I2S_OVERFLOW_COUNT_EN.
module i2s_adc_receiver
  import i2s_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SLOT_BITS  = SLOT_BITS_DEF,
  parameter int SCLK_DIV   = SCLK_DIV_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bclk_in,
  input  logic                  lrclk_in,
  input  logic                  dout_in,
  output logic                  sclk_out,
  output logic [DATA_WIDTH-1:0] i_out,
  output logic [DATA_WIDTH-1:0] q_out,
  output logic                  out_stb,
  input  logic                  out_ack,
  output logic                  overflow_out
`ifdef I2S_OVERFLOW_COUNT_EN
  ,
  output logic [15:0]           overflow_count_out
`endif
);

  localparam int CNT_W = bit_cnt_w(SLOT_BITS);
  localparam logic [CNT_W-1:0] DW_M1    = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] DW_CNT   = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] SLOT_CNT = CNT_W'(SLOT_BITS);
  localparam int SCLK_W = $clog2(SCLK_DIV);
  localparam logic [SCLK_W-1:0] HALF_M1 = SCLK_W'(SCLK_DIV / 2 - 1);

  logic w_bclk_level, w_bclk_rise;
  logic w_lrclk, w_lrclk_rise;
  logic w_dout, w_dout_rise;
  logic w_unused_sync;

  i2s_edge_sync u_sync_bclk (.clk(clk), .rst_n(rst_n), .i_pin(bclk_in),
                             .o_level(w_bclk_level), .o_rise(w_bclk_rise));
  i2s_edge_sync u_sync_lrclk (.clk(clk), .rst_n(rst_n), .i_pin(lrclk_in),
                              .o_level(w_lrclk), .o_rise(w_lrclk_rise));
  i2s_edge_sync u_sync_dout (.clk(clk), .rst_n(rst_n), .i_pin(dout_in),
                             .o_level(w_dout), .o_rise(w_dout_rise));

  assign w_unused_sync = w_bclk_level | w_lrclk_rise | w_dout_rise;

  logic [1:0]            r_state;
  logic                  r_lr_prev;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_left_hold;
  logic                  r_word_done;
  logic [DATA_WIDTH-1:0] r_i;
  logic [DATA_WIDTH-1:0] r_q;
  logic                  r_stb;
  logic                  r_ovf;
  logic [SCLK_W-1:0]     r_sclk_cnt;
  logic                  r_sclk;

  logic                  w_lr_chg;
  logic                  w_data_edge;
  logic                  w_word_done;
  logic                  w_offer;
  logic                  w_drop;
  logic [DATA_WIDTH-1:0] w_shift_next;

  // The lrclk-change edge carries the previous slot's padding bit, so it never shifts.
  assign w_lr_chg     = w_bclk_rise && (w_lrclk != r_lr_prev);
  assign w_data_edge  = w_bclk_rise && (w_lrclk == r_lr_prev);
  assign w_shift_next = {r_shift[DATA_WIDTH-2:0], w_dout};
  assign w_word_done  = w_data_edge && (r_bit_cnt == DW_M1);
  assign w_offer      = w_word_done && (r_state == RIGHT);
  assign w_drop       = w_offer && r_stb && !out_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= HUNT;
      r_lr_prev   <= 1'b0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_left_hold <= '0;
      r_word_done <= 1'b0;
    end else if (w_lr_chg) begin
      r_lr_prev   <= w_lrclk;
      r_bit_cnt   <= '0;
      r_word_done <= 1'b0;
      case (r_state)
        HUNT:    r_state <= w_lrclk ? HUNT : LEFT;
        LEFT:    r_state <= (w_lrclk && r_word_done) ? RIGHT : HUNT;
        RIGHT:   r_state <= (!w_lrclk && r_word_done) ? LEFT : HUNT;
        default: r_state <= HUNT;
      endcase
    end else if (w_data_edge) begin
      if (r_bit_cnt < DW_CNT) r_shift <= w_shift_next;
      if (r_bit_cnt != SLOT_CNT) r_bit_cnt <= r_bit_cnt + 1'b1;
      if (w_word_done) begin
        r_word_done <= 1'b1;
        if (r_state == LEFT) r_left_hold <= w_shift_next;
      end
    end
  end

  // A pending pair may be replaced in the same cycle it is acknowledged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i   <= '0;
      r_q   <= '0;
      r_stb <= 1'b0;
      r_ovf <= 1'b0;
    end else if (w_offer && (!r_stb || out_ack)) begin
      r_i   <= r_left_hold;
      r_q   <= w_shift_next;
      r_stb <= 1'b1;
    end else begin
      if (w_drop) r_ovf <= 1'b1;
      if (r_stb && out_ack) r_stb <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_cnt <= '0;
      r_sclk     <= 1'b0;
    end else if (r_sclk_cnt == HALF_M1) begin
      r_sclk_cnt <= '0;
      r_sclk     <= ~r_sclk;
    end else begin
      r_sclk_cnt <= r_sclk_cnt + 1'b1;
    end
  end

`ifdef I2S_OVERFLOW_COUNT_EN
  logic [15:0] r_ovf_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_cnt <= '0;
    end else if (w_drop && (r_ovf_cnt != 16'hFFFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  assign overflow_count_out = r_ovf_cnt;
`endif

  assign sclk_out     = r_sclk;
  assign i_out        = r_i;
  assign q_out        = r_q;
  assign out_stb      = r_stb;
  assign overflow_out = r_ovf;

endmodule
